// File: rtl/qdiv.sv
// Sequential signed restoring divider: DW-bit dividend by N-bit divisor,
// one quotient bit per cycle, saturating on divide-by-zero and overflow.
module qdiv #(
   parameter int DW = 32,
   parameter int N  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          input_vld,
   input  logic [DW-1:0] dividend_din,
   input  logic [N-1:0]  divisor_din,
   output logic [DW-1:0] quotient_dout,
   output logic [N-1:0]  remainder_dout,
   output logic          quotient_dout_vld,
   output logic          div_end,
   output logic          div_sat
);

   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t        state_q, state_d;
   logic          sa_q, sa_d;
   logic          sb_q, sb_d;
   // dividend magnitude shifts out of the top while quotient bits enter below
   logic [DW-1:0] dvd_q, dvd_d;
   logic [N-1:0]  dsr_q, dsr_d;
   logic [N:0]    rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [N-1:0]  rmd_q, rmd_d;
   logic          vld_q, vld_d;
   logic          sat_q, sat_d;

   logic [N+1:0]  trial;
   logic          qs;

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      sat_d   = sat_q;
      vld_d   = 1'b0;
      trial   = {rem_q, dvd_q[DW-1]} - {2'b00, dsr_q};
      qs      = sa_q ^ sb_q;
      unique case (state_q)
         S_IDLE: begin
            if (ce && input_vld) begin
               sa_d    = dividend_din[DW-1];
               sb_d    = divisor_din[N-1];
               dvd_d   = dividend_din[DW-1] ? -dividend_din : dividend_din;
               dsr_d   = divisor_din[N-1] ? -divisor_din : divisor_din;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            rem_d = trial[N+1] ? {rem_q[N-1:0], dvd_q[DW-1]} : trial[N:0];
            dvd_d = {dvd_q[DW-2:0], ~trial[N+1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW-1)) state_d = S_FIX;
         end
         S_FIX: begin
            vld_d   = 1'b1;
            state_d = S_IDLE;
            if (dsr_q == '0) begin
               quo_d = sa_q ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
               rmd_d = '0;
               sat_d = 1'b1;
            end else if (!qs && dvd_q[DW-1]) begin
               // only -2^(DW-1) / -1 yields a positive 2^(DW-1) magnitude
               quo_d = {1'b0, {(DW-1){1'b1}}};
               rmd_d = '0;
               sat_d = 1'b1;
            end else begin
               quo_d = qs ? -dvd_q : dvd_q;
               rmd_d = sa_q ? -rem_q[N-1:0] : rem_q[N-1:0];
               sat_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         vld_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         vld_q   <= vld_d;
         sat_q   <= sat_d;
      end
   end

   assign quotient_dout     = quo_q;
   assign remainder_dout    = rmd_q;
   assign quotient_dout_vld = vld_q;
   assign div_sat           = sat_q;
   assign div_end           = (state_q == S_IDLE);

endmodule

// File: doc/qdiv.md
# qdiv

Sequential signed integer divider for the quantized inference datapath. It divides a DW-bit signed accumulator value by an N-bit signed scale/divisor using restoring division, producing one quotient bit per cycle. It sits downstream of the Booth multiplier/accumulate stage, consuming its 32-bit results for requantization and averaging. It uses the same single-operation `ce`/`input_vld`/`*_end` handshake as the multiplier.

## Interface
- `DW`, default 32: dividend and quotient width, two's complement.
- `N`, default 8: divisor and remainder width, two's complement. N ≤ DW.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  clock enable; gates acceptance of new operands only.
- `input_vld`  in  1  operands valid.
- `dividend_din`  in  DW  signed dividend.
- `divisor_din`  in  N  signed divisor.
- `quotient_dout`  out  DW  signed quotient, truncated toward zero.
- `remainder_dout`  out  N  signed remainder; its sign follows the dividend.
- `quotient_dout_vld`  out  1  one-cycle result strobe.
- `div_end`  out  1  idle/ready; 1 when no operation is in progress.
- `div_sat`  out  1  result saturated (divide by zero or overflow); valid with `quotient_dout_vld`.

## Operation
- States:
  - IDLE (`div_end`=1).
  - CALC: DW iterations.
  - FIX: sign correction and output register load.
  - FIX returns to IDLE.
- Accept: at an edge where `div_end & ce & input_vld` is true.
  - Latch signs and magnitudes.
    - |dividend| is held as DW-bit unsigned, so |−2^(DW−1)| = 2^(DW−1) is representable.
    - |divisor| is held as N-bit unsigned.
  - Clear the (N+1)-bit partial remainder and the iteration counter.
  - Drive `div_end` to 0 and `quotient_dout_vld` to 0.
- CALC iteration (one per cycle):
  - Shift the partial remainder left, bringing in the next MSB of the dividend magnitude.
  - Trial-subtract |divisor|.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore the remainder and set the bit to 0.
  - Counter runs 0..DW−1, then the block moves to FIX.
- FIX:
  - Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend).
  - Negate the magnitudes as required and register them into `quotient_dout` / `remainder_dout`.
  - Set `quotient_dout_vld`=1 and `div_end`=1.
- Divide by zero (divisor = 0):
  - Still runs the full CALC/FIX sequence, so latency is fixed.
  - Quotient = 2^(DW−1)−1 if dividend ≥ 0, else −2^(DW−1).
  - Remainder = 0, `div_sat`=1.
- Overflow (−2^(DW−1) / −1): quotient = 2^(DW−1)−1, remainder = 0, `div_sat`=1.
- In all other cases `div_sat`=0.
- Operands presented while `div_end`=0 are ignored. They have no effect on the operation in flight and are not queued.
- `ce` low in IDLE blocks acceptance. `ce` has no effect during CALC/FIX.
- `quotient_dout`, `remainder_dout` and `div_sat` hold their values until the next FIX.

## Timing
- Reset values (asynchronous, immediate):
  - `quotient_dout`=0, `remainder_dout`=0, `quotient_dout_vld`=0, `div_end`=1, `div_sat`=0.
  - All internal state is cleared; the FSM goes to IDLE.
- Reset asserted mid-operation aborts the operation. No result strobe is produced. After deassertion the block is in IDLE, ready at the first clock edge.
- Accept edge = E0. CALC occupies edges E1..E_DW. FIX is edge E_(DW+1).
  - Outputs and `quotient_dout_vld` are high after E_(DW+1).
  - Fixed latency: DW+1 cycles (33 at default).
- `quotient_dout_vld` is high for exactly one cycle and clears at E_(DW+2).
- Back-to-back: `div_end` is 1 in the strobe cycle, so a new accept can occur at E_(DW+2).
  - On that edge `quotient_dout_vld` clears, `div_end` drops, and the new operation begins.
  - Maximum throughput is one result per DW+2 cycles.
- Remainder range: |r| ≤ 2^(N−1)−1, so it always fits in N signed bits without truncation.

## Test plan
- Sign combinations: 100/7 → q=14, r=2; −100/7 → q=−14, r=−2; 100/−7 → q=−14, r=2; −100/−7 → q=14, r=−2. For each, `div_sat`=0 and the strobe appears exactly 33 cycles after the accept edge.
- Extremes: −2^31/1 → q=0x80000000, r=0, sat=0. −2^31/−1 → q=0x7FFFFFFF, r=0, sat=1. 0x7FFFFFFF/−128 → q=−16777215, r=127.
- Divide by zero: 5/0 → q=0x7FFFFFFF, r=0, sat=1. −5/0 → q=0x80000000, sat=1. 0/0 → q=0x7FFFFFFF, sat=1. Latency is still 33.
- Handshake:
  - `input_vld` pulsed while busy with 9/3 → first result 100/7 unaffected; no extra strobe.
  - `ce`=0 with `input_vld`=1 in IDLE → no accept, `div_end` stays 1.
  - Back-to-back accept on the cycle after the strobe → two correct results, 34 cycles apart.
- Reset: assert `rst` at cycle 10 of an operation, between clock edges.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - No strobe follows.
  - The next operation 20/3 → q=6, r=2.
- Random: 10,000 random signed pairs, with divisor ≠ 0 excluding the overflow case, compared against a reference model using C-style truncation.
